// File: rtl/traffic_pkg.sv
// Shared interval codes and controller state encoding for the traffic-light FSM.
package traffic_pkg;
  localparam int INT_BASE = 0;
  localparam int INT_EXT  = 1;
  localparam int INT_YEL  = 2;
  localparam int INT_WALK = 3;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    G_BASE = 3'd1,
    G_EXT  = 3'd2,
    YEL    = 3'd3,
    WALK   = 3'd4
  } state_t;
endpackage

// File: rtl/multi_phase_light_fsm_phase_sel.sv
// Next-phase search: lowest q above cur with demand; falls back to phase 0 so main is never skipped.
module phase_sel #(
  parameter int N_PHASES = 3,
  parameter int PW       = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic [N_PHASES-1:0] sensor_i,
  input  logic [PW-1:0]       cur_i,
  output logic [PW-1:0]       nxt_o
);
  always_comb begin
    nxt_o = '0;
    // Walk downward so the lowest qualifying phase is the last assignment.
    for (int q = N_PHASES - 1; q >= 1; q--) begin
      if ((q > int'(cur_i)) && sensor_i[q]) nxt_o = PW'(q);
    end
  end
endmodule

// File: rtl/multi_phase_light_fsm.sv
// N-phase traffic controller: green/extend/yellow per phase, demand-driven skipping, optional walk.
module multi_phase_light_fsm
  import traffic_pkg::*;
#(
  parameter int N_PHASES = 3,
  parameter int INTW     = 3,
  parameter bit WALK_EN  = 1'b1,
  localparam int PW      = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                Prog_Sync,
  input  logic [N_PHASES-1:0] Sensor_Sync,
  input  logic                WR,
  output logic                WR_Reset,
  input  logic                expired,
  output logic                start_timer,
  output logic [INTW-1:0]     interval,
  output logic [N_PHASES-1:0] green,
  output logic [N_PHASES-1:0] yellow,
  output logic [N_PHASES-1:0] red,
  output logic                walk,
  output logic [PW-1:0]       cur_phase
);
  state_t              state_q, state_d;
  logic [PW-1:0]       phase_d;
  logic                ext_used_q, ext_used_d;
  logic                entry;
  logic [PW-1:0]       nxt_phase;
  logic [N_PHASES-1:0] others;
  logic                demand;
  logic                exp_ok;

  logic [N_PHASES-1:0] green_d, yellow_d;
  logic                walk_d;
  logic [INTW-1:0]     interval_d;

  phase_sel #(.N_PHASES(N_PHASES), .PW(PW)) u_sel (
    .sensor_i (Sensor_Sync),
    .cur_i    (cur_phase),
    .nxt_o    (nxt_phase)
  );

  always_comb begin
    others            = Sensor_Sync;
    others[cur_phase] = 1'b0;
    demand            = (|others) || (WR && WALK_EN);
    // A pulse landing on the reload cycle belongs to the previous interval.
    exp_ok            = expired && !start_timer;
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = cur_phase;
    ext_used_d = ext_used_q;
    entry      = 1'b0;
    if (Reset || Prog_Sync) begin
      state_d    = INIT;
      phase_d    = '0;
      ext_used_d = 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          state_d = G_BASE;
          phase_d = '0;
          entry   = 1'b1;
        end
        G_BASE: if (exp_ok) begin
          entry = 1'b1;
          if (Sensor_Sync[cur_phase] && !ext_used_q) begin
            state_d    = G_EXT;
            ext_used_d = 1'b1;
          end else if (demand || (cur_phase != '0)) begin
            state_d = YEL;
          end else begin
            state_d = G_BASE;
          end
        end
        G_EXT: if (exp_ok) begin
          entry   = 1'b1;
          state_d = YEL;
        end
        YEL: if (exp_ok) begin
          entry      = 1'b1;
          ext_used_d = 1'b0;
          phase_d    = nxt_phase;
          state_d    = ((nxt_phase == '0) && WR && WALK_EN) ? WALK : G_BASE;
        end
        WALK: if (exp_ok) begin
          entry   = 1'b1;
          state_d = G_BASE;
          phase_d = '0;
        end
        default: begin
          state_d = INIT;
          phase_d = '0;
        end
      endcase
    end
  end

  // Lamp and interval decode from the next state so the outputs can be registered.
  always_comb begin
    green_d    = '0;
    yellow_d   = '0;
    walk_d     = 1'b0;
    interval_d = INTW'(INT_BASE);
    unique case (state_d)
      G_BASE:  begin green_d[phase_d]  = 1'b1; interval_d = INTW'(INT_BASE); end
      G_EXT:   begin green_d[phase_d]  = 1'b1; interval_d = INTW'(INT_EXT);  end
      YEL:     begin yellow_d[phase_d] = 1'b1; interval_d = INTW'(INT_YEL);  end
      WALK:    begin walk_d = 1'b1;            interval_d = INTW'(INT_WALK); end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= INIT;
      ext_used_q  <= 1'b0;
      cur_phase   <= '0;
      green       <= '0;
      yellow      <= '0;
      red         <= '1;
      walk        <= 1'b0;
      interval    <= INTW'(INT_BASE);
      start_timer <= 1'b0;
      WR_Reset    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_used_q  <= ext_used_d;
      cur_phase   <= phase_d;
      green       <= green_d;
      yellow      <= yellow_d;
      red         <= ~(green_d | yellow_d);
      walk        <= walk_d;
      interval    <= interval_d;
      start_timer <= entry;
      WR_Reset    <= entry && (state_d == WALK);
    end
  end
endmodule
